// File: rtl/data_mem_lsu.sv
// ---------------------------------------------------------------------------
// data_mem_lsu
//   Load/store initiator sitting between the CPU memory stage and data_ram,
//   a word-only RAM with combinational read and synchronous write. Byte and
//   half-word stores are done as read-modify-write, because the RAM can only
//   write whole words. Loads are shifted down to the addressed lane, then
//   sign- or zero-extended.
//
// Parameters
//   SIZE          data_ram depth in 32-bit words (must match data_ram)
//
// Ports
//   clk           clock, all state changes on posedge
//   rst_n         synchronous active-low reset
//   req_valid     request present
//   req_ready     LSU can accept (high only while idle)
//   req_we        1 = store, 0 = load
//   req_size      0 = byte, 1 = half, 2 = word, 3 = illegal
//   req_unsigned  zero-extend loads when 1
//   req_addr      byte address
//   req_wdata     store data, LSB-aligned
//   rsp_valid     one-cycle response strobe
//   rsp_rdata     extended load data (0 for stores and errors)
//   rsp_err       misaligned / out-of-range / illegal size
//   mem_we        data_ram write enable
//   mem_raddr     data_ram read word index
//   mem_waddr     data_ram write word index
//   mem_wdata     data_ram write word
//   mem_rdata     data_ram read word (combinational from mem_raddr)
// ---------------------------------------------------------------------------
module data_mem_lsu #(
  parameter int SIZE = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_we,
  output logic [31:0] mem_raddr,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam logic [29:0] SIZE_W = 30'(SIZE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RMW_RD,
    S_WRITE,
    S_RSP
  } state_e;

  state_e      state_q, state_d;

  // Request latch
  logic [31:0] addr_q,  addr_d;
  logic [1:0]  size_q,  size_d;
  logic        uns_q,   uns_d;
  logic        we_q,    we_d;
  logic [31:0] wdata_q, wdata_d;

  // Old RAM word captured for sub-word stores
  logic [31:0] merge_q, merge_d;

  // Response registers, only updated on entry into S_RSP
  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;

  logic        wr_cycle;

  // -------------------------------------------------------------------------
  // Helpers
  // -------------------------------------------------------------------------

  // Any reason to reject the request without touching the RAM.
  function automatic logic req_error(input logic [1:0]  size,
                                     input logic [31:0] addr);
    logic bad;
    bad = 1'b0;
    if (size == 2'd3)                      bad = 1'b1;
    if ((size == 2'd1) && addr[0])         bad = 1'b1;
    if ((size == 2'd2) && (addr[1:0] != 2'd0)) bad = 1'b1;
    if (addr[31:2] >= SIZE_W)              bad = 1'b1;
    return bad;
  endfunction

  // Bring the addressed lane down to bit 0 and extend it to 32 bits.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  off,
                                               input logic        uns);
    logic [31:0] sh;
    logic [31:0] res;
    sh = word >> {off, 3'b000};
    case (size)
      2'd0:    res = uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
      2'd1:    res = uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  // Replace the addressed byte/half lane of the old word with store data.
  function automatic logic [31:0] merge_word(input logic [31:0] base,
                                             input logic [31:0] wdata,
                                             input logic [1:0]  size,
                                             input logic [1:0]  off);
    logic [31:0] lane_mask;
    logic [31:0] mask;
    logic [31:0] ins;
    lane_mask = (size == 2'd0) ? 32'h0000_00FF : 32'h0000_FFFF;
    mask      = lane_mask << {off, 3'b000};
    ins       = (wdata & lane_mask) << {off, 3'b000};
    return (base & ~mask) | ins;
  endfunction

  // -------------------------------------------------------------------------
  // Next-state and output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    uns_d     = uns_q;
    we_d      = we_q;
    wdata_d   = wdata_q;
    merge_d   = merge_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    wr_cycle  = 1'b0;
    mem_wdata = 32'd0;

    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          size_d  = req_size;
          uns_d   = req_unsigned;
          we_d    = req_we;
          wdata_d = req_wdata;
          if (req_error(req_size, req_addr)) begin
            rdata_d = 32'd0;
            err_d   = 1'b1;
            state_d = S_RSP;
          end else if (!req_we) begin
            state_d = S_LOAD;
          end else if (req_size == 2'd2) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end

      S_LOAD: begin
        rdata_d = load_extract(mem_rdata, size_q, addr_q[1:0], uns_q);
        err_d   = 1'b0;
        state_d = S_RSP;
      end

      S_RMW_RD: begin
        merge_d = mem_rdata;
        state_d = S_WRITE;
      end

      S_WRITE: begin
        wr_cycle  = 1'b1;
        mem_wdata = (size_q == 2'd2) ? wdata_q
                                     : merge_word(merge_q, wdata_q, size_q, addr_q[1:0]);
        rdata_d   = 32'd0;
        err_d     = 1'b0;
        state_d   = S_RSP;
      end

      S_RSP: begin
        // A reset in this cycle aborts the access, so no strobe either.
        rsp_valid = rst_n;
        state_d   = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Reset is synchronous, so gate the write strobe directly to keep the RAM
  // from being written in the very cycle reset is asserted.
  assign mem_we    = wr_cycle && rst_n;
  assign mem_raddr = {2'b00, addr_q[31:2]};
  assign mem_waddr = {2'b00, addr_q[31:2]};
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= 32'd0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      we_q    <= 1'b0;
      wdata_q <= 32'd0;
      merge_q <= 32'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      merge_q <= merge_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_data_mem_lsu.sv
// ---------------------------------------------------------------------------
// tb_data_mem_lsu
//   Bench for data_mem_lsu with a behavioural data_ram and a byte-array
//   reference memory. Directed vectors come from a table; multi-cycle corner
//   cases (reset during a write, back-to-back requests) are hand-written;
//   the rest is random traffic checked against the reference model.
// ---------------------------------------------------------------------------
module tb_data_mem_lsu;

  localparam int SIZE = 64;
  localparam int AW   = $clog2(SIZE);

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_we;
  logic [31:0] mem_raddr;
  logic [31:0] mem_waddr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  data_mem_lsu #(.SIZE(SIZE)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .mem_we       (mem_we),
    .mem_raddr    (mem_raddr),
    .mem_waddr    (mem_waddr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- data_ram model ----------------
  logic [31:0] ram [SIZE];
  logic        ram_init;

  function automatic logic [31:0] pat(input int i);
    return 32'(i) * 32'h9E37_79B1 + 32'h0123_4567;
  endfunction

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < SIZE; i++) ram[i] <= pat(i);
    end else if (mem_we && (mem_waddr < 32'(SIZE))) begin
      ram[mem_waddr[AW-1:0]] <= mem_wdata;
    end
  end

  assign mem_rdata = (mem_raddr < 32'(SIZE)) ? ram[mem_raddr[AW-1:0]] : 32'hBAD0_BAD0;

  // ---------------- reference model (byte addressed, little endian) -------
  logic [7:0] rbytes [4*SIZE];

  function automatic bit ref_err(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd3) return 1'b1;
    if ((sz == 2'd1) && (a % 2 != 0)) return 1'b1;
    if ((sz == 2'd2) && (a % 4 != 0)) return 1'b1;
    if ((a / 4) >= 32'(SIZE)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz,
                                           input logic un);
    int n;
    logic [31:0] v;
    n = 1 << sz;
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(rbytes[int'(a) + i]) << (8 * i));
    if (!un && (n < 4) && (v >= (32'd1 << (8 * n - 1)))) v = v - (32'd1 << (8 * n));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n;
    n = 1 << sz;
    for (int i = 0; i < n; i++) rbytes[int'(a) + i] = 8'(wd >> (8 * i));
  endtask

  // ---------------- checking ----------------
  int n_cmp;
  int n_fail;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, wanted 0x%08h", nm, act, exp);
    end
  endtask

  // One request through the handshake; reports what came back.
  task automatic xact(input logic we, input logic [1:0] sz, input logic un,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output logic er, output int lat,
                      output int nwe, output logic [31:0] wa, output bit idle_wd_bad);
    int  w;
    bit  got;
    rd = 32'd0; er = 1'b0; lat = 0; nwe = 0; wa = 32'd0; idle_wd_bad = 1'b0;
    w = 0;
    @(negedge clk);
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!req_ready) begin
      chk("ready_timeout", 32'(req_ready), 32'd1);
      lat = -1;
      return;
    end
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0;
    while (!got && lat < 10) begin
      @(negedge clk);
      lat++;
      if (mem_we) begin
        nwe++;
        wa = mem_waddr;
      end else if (mem_wdata != 32'd0) begin
        idle_wd_bad = 1'b1;
      end
      if (rsp_valid) begin
        got = 1'b1;
        rd  = rsp_rdata;
        er  = rsp_err;
      end
    end
    if (!got) lat = -1;
  endtask

  task automatic run_chk(input string nm, input logic we, input logic [1:0] sz,
                         input logic un, input logic [31:0] a, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eer, input int elat);
    logic [31:0] rd, wa;
    logic        er;
    int          lat, nwe;
    bit          bad;
    xact(we, sz, un, a, wd, rd, er, lat, nwe, wa, bad);
    chk({nm, ".rdata"}, rd, erd);
    chk({nm, ".err"}, 32'(er), 32'(eer));
    chk({nm, ".latency"}, 32'(lat), 32'(elat));
    chk({nm, ".mem_we_pulses"}, 32'(nwe), (we && !eer) ? 32'd1 : 32'd0);
    if (nwe != 0) chk({nm, ".waddr"}, wa, a >> 2);
    chk({nm, ".idle_wdata"}, 32'(bad), 32'd0);
    if (we && !eer) ref_store(a, sz, wd);
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] erd;
    logic        eer;
    int          elat;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic we, input logic [1:0] sz, input logic un,
                              input logic [31:0] a, input logic [31:0] wd,
                              input logic [31:0] erd, input logic eer, input int elat);
    vec_t v;
    v.we = we; v.sz = sz; v.un = un; v.a = a; v.wd = wd;
    v.erd = erd; v.eer = eer; v.elat = elat;
    return v;
  endfunction

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [31:0] exp_b2b [4];
    logic [31:0] b2b_addr [4];
    int nacc, nrsp, prev;
    n_cmp = 0; n_fail = 0;
    ram_init = 1'b0;
    rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'd0; req_wdata = 32'd0;
    for (int i = 0; i < SIZE; i++)
      for (int k = 0; k < 4; k++) rbytes[4*i + k] = 8'(pat(i) >> (8 * k));

    tbl[0]  = mk(1, 2, 0, 32'h10,    32'hDEADBEEF, 32'h0,        0, 2);
    tbl[1]  = mk(0, 2, 0, 32'h10,    32'h0,        32'hDEADBEEF, 0, 2);
    tbl[2]  = mk(1, 2, 0, 32'h10,    32'h11223344, 32'h0,        0, 2);
    tbl[3]  = mk(1, 0, 0, 32'h12,    32'h000000AA, 32'h0,        0, 3);
    tbl[4]  = mk(0, 2, 0, 32'h10,    32'h0,        32'h11AA3344, 0, 2);
    tbl[5]  = mk(1, 2, 0, 32'h10,    32'h80FF7F01, 32'h0,        0, 2);
    tbl[6]  = mk(0, 0, 0, 32'h13,    32'h0,        32'hFFFFFF80, 0, 2);
    tbl[7]  = mk(0, 0, 1, 32'h13,    32'h0,        32'h00000080, 0, 2);
    tbl[8]  = mk(0, 1, 0, 32'h12,    32'h0,        32'hFFFF80FF, 0, 2);
    tbl[9]  = mk(0, 1, 1, 32'h10,    32'h0,        32'h00007F01, 0, 2);
    tbl[10] = mk(1, 1, 0, 32'h11,    32'h0000BEEF, 32'h0,        1, 1);
    tbl[11] = mk(0, 2, 0, 32'h12,    32'h0,        32'h0,        1, 1);
    tbl[12] = mk(0, 3, 0, 32'h20,    32'h0,        32'h0,        1, 1);
    tbl[13] = mk(1, 2, 0, 32'(4*SIZE), 32'h12345678, 32'h0,      1, 1);
    tbl[14] = mk(0, 2, 0, 32'h10,    32'h0,        32'h80FF7F01, 0, 2);

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset.req_ready", 32'(req_ready), 32'd1);
    chk("reset.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset.rsp_err",   32'(rsp_err),   32'd0);
    chk("reset.rsp_rdata", rsp_rdata,      32'd0);
    chk("reset.mem_we",    32'(mem_we),    32'd0);
    chk("reset.mem_wdata", mem_wdata,      32'd0);
    ram_init = 1'b1;
    rst_n = 1'b1;

    foreach (tbl[i])
      run_chk($sformatf("tbl%0d", i), tbl[i].we, tbl[i].sz, tbl[i].un, tbl[i].a,
              tbl[i].wd, tbl[i].erd, tbl[i].eer, tbl[i].elat);

    // Reset while the sub-word store is in its write cycle
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h55;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);                       // read phase
    @(negedge clk);                       // write phase
    chk("rstmid.we_before", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1 chk("rstmid.we_in_reset", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("rstmid.rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rstmid.idle",      32'(req_ready), 32'd1);
    chk("rstmid.rdata",     rsp_rdata,      32'd0);
    rst_n = 1'b1;
    nrsp = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) nrsp++;
    end
    chk("rstmid.no_rsp", 32'(nrsp), 32'd0);
    run_chk("rstmid.readback", 0, 2, 0, 32'h10, 32'h0, 32'h80FF7F01, 0, 2);

    // Back-to-back loads with req_valid held high
    for (int i = 0; i < 4; i++) begin
      b2b_addr[i] = 32'(4 * (i + 2));
      exp_b2b[i]  = ref_load(b2b_addr[i], 2'd2, 1'b0);
    end
    @(negedge clk);
    nacc = 0; nrsp = 0; prev = -1;
    req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    for (int c = 0; c < 40 && (nacc < 4 || nrsp < 4); c++) begin
      if (rsp_valid) begin
        if (nrsp < 4) chk($sformatf("b2b.rdata%0d", nrsp), rsp_rdata, exp_b2b[nrsp]);
        nrsp++;
      end
      if (req_ready) begin
        if (nacc < 4) begin
          req_addr  = b2b_addr[nacc];
          req_valid = 1'b1;
          if (nacc > 0) chk($sformatf("b2b.spacing%0d", nacc), 32'(c - prev), 32'd3);
          prev = c;
          nacc++;
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    chk("b2b.accepts",   32'(nacc), 32'd4);
    chk("b2b.responses", 32'(nrsp), 32'd4);

    // Random traffic against the reference model
    for (int t = 0; t < 300; t++) begin
      logic        we, un, e;
      logic [1:0]  sz;
      logic [31:0] a, wd, erd;
      int          elat;
      we = 1'($urandom_range(0, 1));
      un = 1'($urandom_range(0, 1));
      sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      wd = $urandom;
      case ($urandom_range(0, 9))
        0:       a = $urandom;
        1:       a = 32'(4 * SIZE + $urandom_range(0, 7));
        default: a = 32'($urandom_range(0, 4 * SIZE - 1));
      endcase
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      e = ref_err(sz, a);
      if (e)       begin erd = 32'd0; elat = 1; end
      else if (!we) begin erd = ref_load(a, sz, un); elat = 2; end
      else          begin erd = 32'd0; elat = (sz == 2'd2) ? 2 : 3; end
      run_chk($sformatf("rnd%0d", t), we, sz, un, a, wd, erd, e, elat);
    end

    // Final RAM image
    @(negedge clk);
    for (int i = 0; i < SIZE; i++)
      chk($sformatf("ram[%0d]", i), ram[i],
          {rbytes[4*i+3], rbytes[4*i+2], rbytes[4*i+1], rbytes[4*i]});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
